mem_arbiter_rr: RTL and testbench

- Parametrised N-client arbiter for the shared SDRAM request path. It is the successor to the fixed-priority arbiter between the display/TFT clients and the sdram controller.
- Adds a selectable round-robin mode, a per-client enable mask, and write-burst locking, so a write burst of BURST words is never interleaved.
- Routes returned read data back to the issuing client by ID.
- Sits in the clkSYS domain between client request ports and the sdram request/ack/valid interface.

---
 rtl/mem_arbiter_rr.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-client SDRAM request arbiter: round-robin or fixed priority, per-client enable mask,
// locked write bursts of BURST words, and ID-routed read data return.
module mem_arbiter_rr #(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int N     = 4,
    parameter int IDN   = 2,
    parameter int BURST = 8,
    parameter int RR    = 1
) (
    input  logic            clkSYS,
    input  logic            reset,
    input  logic [N-1:0]    en,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    wr,
    input  logic [N*AN-1:0] addr,
    input  logic [N*DN-1:0] data,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    rvalid,
    output logic [DN-1:0]   rdata,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [AN-1:0]   mem_addr,
    output logic [DN-1:0]   mem_data,
    output logic [IDN-1:0]  mem_id,
    input  logic            mem_ack,
    input  logic            mem_valid,
    input  logic [DN-1:0]   mem_rdata,
    input  logic [IDN-1:0]  mem_rid,
    output logic            busy,
    output logic [IDN-1:0]  grant
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDN-1:0]   ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [N-1:0]     cand_s;
    logic             found_s;
    logic [IDN-1:0]   win_s;
    logic [IDN:0]     idx_s;
    logic             beat_s;

    assign cand_s = req & en;
    assign busy   = (state_r != IDLE);
    // A beat only counts when the granted client is actually presenting a request.
    assign beat_s = req[grant] & mem_ack;

    // Winner search: scan from ptr+1 with wrap in round-robin mode, from 0 otherwise.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            if (RR != 0) begin
                idx_s = {1'b0, ptr_r} + (IDN+1)'(k);
            end else begin
                idx_s = (IDN+1)'(k - 1);
            end
            if (idx_s >= (IDN+1)'(N)) begin
                idx_s = idx_s - (IDN+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && cand_s[idx_s[IDN-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IDN-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Arbitration FSM: grant latch, round-robin pointer and write-burst beat counter.
    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            grant   <= '0;
            ptr_r   <= IDN'(N - 1);
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant   <= win_s;
                        ptr_r   <= win_s;
                        cnt_r   <= '0;
                        state_r <= wr[win_s] ? WRITE : READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (beat_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= READ;
                    end
                end
                WRITE: begin
                    if (beat_s) begin
                        if (cnt_r == CW'(BURST - 1)) begin
                            state_r <= IDLE;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Request datapath: mux the granted client onto the sdram port while a grant is held.
    always_comb begin
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        mem_id   = '0;
        ack      = '0;
        if (state_r != IDLE) begin
            mem_req    = req[grant];
            mem_wr     = wr[grant];
            mem_addr   = addr[int'(grant)*AN +: AN];
            mem_data   = data[int'(grant)*DN +: DN];
            mem_id     = grant;
            ack[grant] = beat_s;
        end else begin
            ack = '0;
        end
    end

    // Read return: decode the returned ID; silenced while reset is asserted.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < N; i++) begin
            rvalid[i] = mem_valid && (mem_rid == IDN'(i)) && !reset;
        end
        if (reset) begin
            rdata = '0;
        end else begin
            rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a cycle table run against round-robin and
// fixed-priority instances, plus hand sequences for bursts, stalls and reset.
module tb_mem_arbiter_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  en, req, wr;
    logic [95:0] addr;
    logic [63:0] data;
    logic        mem_ack, mem_valid;
    logic [15:0] mem_rdata;
    logic [1:0]  mem_rid;

    logic [3:0]  rr_ack, rr_rvalid, fp_ack, fp_rvalid;
    logic [15:0] rr_rdata, rr_mem_data, fp_rdata, fp_mem_data;
    logic        rr_mem_req, rr_mem_wr, rr_busy, fp_mem_req, fp_mem_wr, fp_busy;
    logic [23:0] rr_mem_addr, fp_mem_addr;
    logic [1:0]  rr_mem_id, rr_grant, fp_mem_id, fp_grant;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.AN(24), .DN(16), .N(4), .IDN(2), .BURST(8), .RR(1)) u_rr (
        .clkSYS(clk), .reset(reset), .en(en), .req(req), .wr(wr), .addr(addr), .data(data),
        .ack(rr_ack), .rvalid(rr_rvalid), .rdata(rr_rdata), .mem_req(rr_mem_req),
        .mem_wr(rr_mem_wr), .mem_addr(rr_mem_addr), .mem_data(rr_mem_data), .mem_id(rr_mem_id),
        .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
        .busy(rr_busy), .grant(rr_grant));

    mem_arbiter_rr #(.AN(24), .DN(16), .N(4), .IDN(2), .BURST(8), .RR(0)) u_fp (
        .clkSYS(clk), .reset(reset), .en(en), .req(req), .wr(wr), .addr(addr), .data(data),
        .ack(fp_ack), .rvalid(fp_rvalid), .rdata(fp_rdata), .mem_req(fp_mem_req),
        .mem_wr(fp_mem_wr), .mem_addr(fp_mem_addr), .mem_data(fp_mem_data), .mem_id(fp_mem_id),
        .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
        .busy(fp_busy), .grant(fp_grant));

    typedef struct {
        logic        rst;
        logic [3:0]  en, req, wr;
        logic        mack, mvalid;
        logic [1:0]  mrid;
        logic [15:0] mrdata;
        logic        e_mreq;
        logic [3:0]  e_ack;
        logic        e_busy;
        logic [1:0]  e_grant;
        logic [3:0]  e_rvalid;
        logic [3:0]  e_ack0;
        logic [1:0]  e_grant0;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic [3:0] ven, input logic [3:0] vreq,
                       input logic [3:0] vwr, input logic mack, input logic mvalid,
                       input logic [1:0] mrid, input logic [15:0] mrdata,
                       input logic e_mreq, input logic [3:0] e_ack, input logic e_busy,
                       input logic [1:0] e_grant, input logic [3:0] e_rvalid,
                       input logic [3:0] e_ack0, input logic [1:0] e_grant0);
        vec_t v;
        v.rst = rst; v.en = ven; v.req = vreq; v.wr = vwr; v.mack = mack; v.mvalid = mvalid;
        v.mrid = mrid; v.mrdata = mrdata; v.e_mreq = e_mreq; v.e_ack = e_ack; v.e_busy = e_busy;
        v.e_grant = e_grant; v.e_rvalid = e_rvalid; v.e_ack0 = e_ack0; v.e_grant0 = e_grant0;
        vecs.push_back(v);
    endtask

    function automatic logic [23:0] addr_of(input logic [1:0] g);
        return addr[int'(g)*24 +: 24];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'h0; wr = 4'h0; en = 4'hF;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rid = 2'd0; mem_rdata = 16'h0000;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] e_addr;
        logic [1:0]  e_id;
        logic [15:0] e_rdata;
        logic        ok;
        int          acks2;

        for (int i = 0; i < 4; i++) begin
            addr[i*24 +: 24] = 24'h000100 + 24'(i) * 24'h001000;
            data[i*16 +: 16] = 16'hD000 + 16'(i);
        end
        reset = 1'b1; en = 4'hF; req = 4'h0; wr = 4'h0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rid = 2'd0; mem_rdata = 16'h0000;

        //   rst en   req  wr   ack v  rid rdata     mreq ack  busy g  rvalid ack0 g0
        row(1, 4'hF, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'h1, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'h1, 4'h0, 0, 0, 0, 16'h0000, 1, 4'h0, 1, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'h1, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h1, 1, 0, 4'h0, 4'h1, 0);
        row(0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        // all four clients read, mem_ack every other cycle
        row(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h1, 1, 0, 4'h0, 4'h1, 0);
        row(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h2, 1, 1, 4'h0, 4'h1, 0);
        row(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h4, 1, 2, 4'h0, 4'h1, 0);
        row(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 2, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h8, 1, 3, 4'h0, 4'h1, 0);
        row(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 3, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h1, 1, 0, 4'h0, 4'h1, 0);
        // mem_ack while idle is ignored; masked client never granted until enabled
        row(0, 4'hF, 4'h0, 4'h0, 1, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hD, 4'h2, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hD, 4'h2, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'h2, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        row(0, 4'hF, 4'h2, 4'h0, 0, 0, 0, 16'h0000, 1, 4'h0, 1, 1, 4'h0, 4'h0, 1);
        row(0, 4'h0, 4'h2, 4'h0, 1, 0, 0, 16'h0000, 1, 4'h2, 1, 1, 4'h0, 4'h2, 1);
        row(0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 1, 4'h0, 4'h0, 1);
        row(0, 4'hF, 4'h0, 4'h0, 0, 1, 3, 16'hBEEF, 0, 4'h0, 0, 1, 4'h8, 4'h0, 1);
        row(0, 4'hF, 4'h0, 4'h0, 0, 1, 2, 16'h1234, 0, 4'h0, 0, 1, 4'h4, 4'h0, 1);

        cyc();
        foreach (vecs[i]) begin
            reset = vecs[i].rst; en = vecs[i].en; req = vecs[i].req; wr = vecs[i].wr;
            mem_ack = vecs[i].mack; mem_valid = vecs[i].mvalid;
            mem_rid = vecs[i].mrid; mem_rdata = vecs[i].mrdata;
            #3;
            e_id    = vecs[i].e_busy ? vecs[i].e_grant : 2'd0;
            e_addr  = vecs[i].e_busy ? addr_of(vecs[i].e_grant) : 24'h000000;
            e_rdata = vecs[i].rst ? 16'h0000 : vecs[i].mrdata;
            ok = (rr_mem_req === vecs[i].e_mreq) && (rr_ack === vecs[i].e_ack) &&
                 (rr_busy === vecs[i].e_busy) && (rr_grant === vecs[i].e_grant) &&
                 (rr_rvalid === vecs[i].e_rvalid) && (rr_rdata === e_rdata) &&
                 (rr_mem_id === e_id) && (rr_mem_addr === e_addr) &&
                 (fp_ack === vecs[i].e_ack0) && (fp_grant === vecs[i].e_grant0);
            nvec++;
            if (!ok) begin
                nerr++;
                $display("FAIL vec%0d: got req=%b ack=%b busy=%b g=%0d rv=%b rd=%h id=%0d a=%h ack0=%b g0=%0d; expected req=%b ack=%b busy=%b g=%0d rv=%b rd=%h id=%0d a=%h ack0=%b g0=%0d",
                         i, rr_mem_req, rr_ack, rr_busy, rr_grant, rr_rvalid, rr_rdata, rr_mem_id,
                         rr_mem_addr, fp_ack, fp_grant, vecs[i].e_mreq, vecs[i].e_ack,
                         vecs[i].e_busy, vecs[i].e_grant, vecs[i].e_rvalid, e_rdata, e_id, e_addr,
                         vecs[i].e_ack0, vecs[i].e_grant0);
            end
            cyc();
        end

        // Locked write burst from client 2; client 0 joins at beat 3
        do_reset();
        req = 4'b0100; wr = 4'b0100;
        #3 chk("burst_idle_busy", 32'(rr_busy), 32'd0);
        cyc();
        acks2 = 0;
        for (int b = 0; b < 8; b++) begin
            if (b == 3) req = 4'b0101;
            mem_ack = 1'b1;
            #3;
            if (rr_ack == 4'b0100) acks2++;
            chk("burst_ack", 32'(rr_ack), 32'h4);
            chk("burst_id", 32'(rr_mem_id), 32'd2);
            chk("burst_wr", 32'(rr_mem_wr), 32'd1);
            chk("burst_data", 32'(rr_mem_data), 32'hD002);
            cyc();
        end
        req = 4'b0001; mem_ack = 1'b0;
        #3;
        chk("burst_ack_count", 32'(acks2), 32'd8);
        chk("burst_end_busy", 32'(rr_busy), 32'd0);
        cyc();
        #3;
        chk("burst_next_grant", 32'(rr_grant), 32'd0);
        chk("burst_next_busy", 32'(rr_busy), 32'd1);
        chk("burst_next_wr", 32'(rr_mem_wr), 32'd0);
        chk("burst_next_addr", 32'(rr_mem_addr), 32'h000100);

        // Client 1 write burst stalls for 5 cycles after 4 beats
        do_reset();
        req = 4'b0010; wr = 4'b0010;
        cyc();
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b1;
            #3 chk("stall_pre_ack", 32'(rr_ack), 32'h2);
            cyc();
        end
        req = 4'b0000;
        for (int b = 0; b < 5; b++) begin
            #3;
            chk("stall_gap_req", 32'(rr_mem_req), 32'd0);
            chk("stall_gap_ack", 32'(rr_ack), 32'h0);
            chk("stall_gap_grant", 32'(rr_grant), 32'd1);
            chk("stall_gap_busy", 32'(rr_busy), 32'd1);
            cyc();
        end
        req = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            #3;
            chk("stall_post_ack", 32'(rr_ack), 32'h2);
            chk("stall_post_busy", 32'(rr_busy), 32'd1);
            cyc();
        end
        req = 4'b0000; mem_ack = 1'b0;
        #3 chk("stall_end_busy", 32'(rr_busy), 32'd0);

        // Read return during a client-0 write, then reset mid-burst
        do_reset();
        req = 4'b0001; wr = 4'b0001;
        cyc();
        mem_ack = 1'b1;
        cyc();
        cyc();
        mem_ack = 1'b0; mem_valid = 1'b1; mem_rid = 2'd3; mem_rdata = 16'hBEEF;
        #3;
        chk("rret_rvalid", 32'(rr_rvalid), 32'h8);
        chk("rret_rdata", 32'(rr_rdata), 32'hBEEF);
        chk("rret_grant", 32'(rr_grant), 32'd0);
        reset = 1'b1; mem_ack = 1'b1;
        #1;
        chk("rst_mem_req", 32'(rr_mem_req), 32'd0);
        chk("rst_ack", 32'(rr_ack), 32'h0);
        chk("rst_busy", 32'(rr_busy), 32'd0);
        chk("rst_rvalid", 32'(rr_rvalid), 32'h0);
        chk("rst_rdata", 32'(rr_rdata), 32'h0);
        chk("rst_addr", 32'(rr_mem_addr), 32'h0);
        chk("rst_data", 32'(rr_mem_data), 32'h0);
        chk("rst_wr", 32'(rr_mem_wr), 32'd0);
        mem_valid = 1'b0;
        cyc();
        #1 chk("rst_hold_ack", 32'(rr_ack), 32'h0);
        reset = 1'b0; req = 4'hF; wr = 4'h0; mem_ack = 1'b0;
        #2 chk("rst_release_busy", 32'(rr_busy), 32'd0);
        cyc();
        #3;
        chk("rst_first_grant", 32'(rr_grant), 32'd0);
        chk("rst_first_busy", 32'(rr_busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
